load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and access-decode helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'b00,
      CAUSE_MISALIGNED = 2'b01,
      CAUSE_ILLEGAL    = 2'b10,
      CAUSE_TIMEOUT    = 2'b11
   } cause_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Illegal encodings win over misalignment.
   function automatic cause_t check_access(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] offset);
      logic legal;
      if (is_store)
         legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
      if (!legal)
         return CAUSE_ILLEGAL;
      if ((f3[1:0] == 2'b01 && offset[0]) || (f3[1:0] == 2'b10 && offset != 2'b00))
         return CAUSE_MISALIGNED;
      return CAUSE_NONE;
   endfunction

   function automatic logic [3:0] byte_enables(input logic is_store, input logic [2:0] f3,
                                               input logic [1:0] offset);
      if (!is_store)
         return 4'b1111;
      case (f3[1:0])
         2'b00:   return 4'b0001 << offset;
         2'b01:   return 4'b0011 << offset;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] data);
      case (f3[1:0])
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword from a read word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   // NOTE: every path assigns data, so no latch is inferred.
   always_comb begin
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   data = {24'b0, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   data = {16'b0, shifted[15:0]};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes the access, drives one memory request,
// and returns an aligned load result or a fault with a one-cycle done pulse.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        done,
   output logic [31:0] load_data,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_be,
   input  logic        m_ack,
   input  logic [31:0] m_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [31:0]   rdata_q;
   cause_t        cause_q;
   cause_t        req_cause;
   logic [31:0]   aligned;

   assign req_cause   = check_access(mem_write, funct3, addr[1:0]);
   assign stall       = start && (state != ST_RESP);
   assign fault_cause = cause_q;
   assign load_data   = (done && !we_q && !fault) ? aligned : 32'b0;

   lsu_load_align u_align (
      .rdata  (rdata_q),
      .funct3 (f3_q),
      .offset (off_q),
      .data   (aligned)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; done/fault default low here so they pulse only in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         off_q   <= 2'b0;
         rdata_q <= 32'b0;
         cause_q <= CAUSE_NONE;
         done    <= 1'b0;
         fault   <= 1'b0;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= 32'b0;
         m_wdata <= 32'b0;
         m_be    <= 4'b0;
      end else begin
         done    <= 1'b0;
         fault   <= 1'b0;
         cause_q <= CAUSE_NONE;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  we_q  <= mem_write;
                  f3_q  <= funct3;
                  off_q <= addr[1:0];
                  if (req_cause != CAUSE_NONE) begin
                     state   <= ST_RESP;
                     done    <= 1'b1;
                     fault   <= 1'b1;
                     cause_q <= req_cause;
                  end else begin
                     state   <= ST_BUSY;
                     cnt     <= '0;
                     m_req   <= 1'b1;
                     m_we    <= mem_write;
                     m_addr  <= {addr[31:2], 2'b00};
                     m_wdata <= mem_write ? lane_data(funct3, store_data) : 32'b0;
                     m_be    <= byte_enables(mem_write, funct3, addr[1:0]);
                  end
               end
            end
            ST_BUSY: begin
               if (m_ack || cnt == CNT_LAST) begin
                  state   <= ST_RESP;
                  done    <= 1'b1;
                  m_req   <= 1'b0;
                  m_we    <= 1'b0;
                  m_addr  <= 32'b0;
                  m_wdata <= 32'b0;
                  m_be    <= 4'b0;
                  if (m_ack) begin
                     rdata_q <= m_rdata;
                  end else begin
                     fault   <= 1'b1;
                     cause_q <= CAUSE_TIMEOUT;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        stall;
   logic        done;
   logic [31:0] load_data;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_ack;
   logic [31:0] m_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mem_write   (mem_write),
      .funct3      (funct3),
      .addr        (addr),
      .store_data  (store_data),
      .stall       (stall),
      .done        (done),
      .load_data   (load_data),
      .fault       (fault),
      .fault_cause (fault_cause),
      .m_req       (m_req),
      .m_we        (m_we),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_be        (m_be),
      .m_ack       (m_ack),
      .m_rdata     (m_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: access size in bytes and plain arithmetic on byte offsets.
   function automatic int size_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [1:0] model_cause(input logic we, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      if (!legal) return 2'd2;
      if (int'(a[1:0]) % size_of(f3) != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      int     sz;
      longint span;
      longint v;
      sz = size_of(f3);
      if (sz == 4) return rd;
      span = longint'(1) << (8 * sz);
      v = (longint'(rd) >> (8 * int'(a[1:0]))) % span;
      if (f3 < 3'd4 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int m;
      if (!we) return 4'hF;
      m = ((1 << size_of(f3)) - 1) << int'(a[1:0]);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      case (size_of(f3))
         1:       return (sd % 32'd256) * 32'h0101_0101;
         2:       return (sd % 32'd65536) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   // Entered and left at a negedge with the DUT idle.
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int ack_delay, input logic [31:0] rd,
                         input bit drop_start, output logic [31:0] got_load,
                         output logic [1:0] got_cause);
      logic [1:0] cause;
      logic [1:0] exp_cause;
      int         n_busy;
      bit         tout;
      cause = model_cause(we, f3, a);
      tout  = 1'b0;
      if (cause != 2'd0) n_busy = 0;
      else if (ack_delay < TO) n_busy = ack_delay + 1;
      else begin
         n_busy = TO;
         tout   = 1'b1;
      end
      start = 1'b1; mem_write = we; funct3 = f3; addr = a; store_data = sd; m_ack = 1'b0;
      #1 check("stall_idle", stall, 1);
      for (int k = 0; k < n_busy; k++) begin
         @(negedge clk);
         check("m_req", m_req, 1);
         check("m_we", m_we, we);
         check("m_addr", m_addr, a & ~32'h3);
         check("m_be", m_be, model_be(we, f3, a));
         if (we) check("m_wdata", m_wdata, model_wdata(f3, sd));
         check("done_busy", done, 0);
         check("stall_busy", stall, 1);
         mem_write = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
         m_ack   = (k == ack_delay);
         m_rdata = m_ack ? rd : $urandom;
      end
      @(negedge clk);
      m_ack = 1'b0;
      exp_cause = tout ? 2'd3 : cause;
      check("done", done, 1);
      check("fault", fault, exp_cause != 2'd0);
      check("fault_cause", fault_cause, exp_cause);
      check("load_data", load_data, (we || exp_cause != 2'd0) ? 32'd0 : model_load(f3, a, rd));
      check("m_req_resp", m_req, 0);
      check("stall_resp", stall, 0);
      got_load  = load_data;
      got_cause = fault_cause;
      if (drop_start) start = 1'b0;
      @(negedge clk);
      check("done_idle", done, 0);
      check("m_req_idle", m_req, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] gl;
      logic [1:0]  gc;
      rst = 1'b1; start = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = 32'b0;
      store_data = 32'b0; m_ack = 1'b0; m_rdata = 32'b0;
      repeat (2) @(negedge clk);
      check("rst_done", done, 0);
      check("rst_fault", fault, 0);
      check("rst_cause", fault_cause, 0);
      check("rst_load", load_data, 0);
      check("rst_req", m_req, 0);
      check("rst_we", m_we, 0);
      check("rst_addr", m_addr, 0);
      check("rst_wdata", m_wdata, 0);
      check("rst_be", m_be, 0);
      check("rst_stall", stall, 0);

      // First start is accepted on the first edge after reset release.
      rst = 1'b0;
      run_op(0, 3'b010, 32'h40, 0, 0, 32'h0BAD_F00D, 1, gl, gc);

      run_op(0, 3'b010, 32'h100, 0, 0, 32'hDEAD_BEEF, 1, gl, gc);
      check("lw_value", gl, 32'hDEAD_BEEF);
      run_op(0, 3'b000, 32'h103, 0, 0, 32'h8011_2233, 1, gl, gc);
      check("lb_sign", gl, 32'hFFFF_FF80);
      run_op(0, 3'b100, 32'h103, 0, 0, 32'h8011_2233, 1, gl, gc);
      check("lbu_zero", gl, 32'h0000_0080);
      run_op(1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 1, gl, gc);
      check("sh_no_load", gl, 0);
      run_op(0, 3'b010, 32'h101, 0, 0, 0, 1, gl, gc);
      check("lw_misaligned", gc, 2'b01);
      run_op(0, 3'b111, 32'h100, 0, 0, 0, 1, gl, gc);
      check("ld_illegal", gc, 2'b10);
      run_op(1, 3'b011, 32'h101, 32'h55, 0, 0, 1, gl, gc);
      check("illegal_over_misaligned", gc, 2'b10);
      run_op(0, 3'b010, 32'h100, 0, 99, 0, 1, gl, gc);
      check("timeout", gc, 2'b11);
      run_op(0, 3'b001, 32'h102, 0, TO - 1, 32'hFFFF_1234, 1, gl, gc);
      check("ack_on_last_cycle", gc, 2'b00);
      check("lh_sign_high", gl, 32'hFFFF_FFFF);

      // Reset mid-BUSY drops the request immediately and yields no done pulse.
      start = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300; m_ack = 1'b0;
      @(negedge clk);
      check("rstbusy_req", m_req, 1);
      #2 rst = 1'b1;
      #1 check("rstbusy_req_async", m_req, 0);
      check("rstbusy_done", done, 0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_done", done, 0);
         check("post_rst_req", m_req, 0);
      end

      for (int i = 0; i < 150; i++) begin
         run_op(1'($urandom_range(0, 1)), 3'($urandom), 32'h1000 + $urandom_range(0, 255),
                $urandom, int'($urandom_range(0, TO + 1)), $urandom,
                (i == 149) || ($urandom_range(0, 3) != 0), gl, gc);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
